// File: rtl/count_pwm_pkg.sv
// count_pwm_pkg: shared constants, pending-slot state type and duty clamp
// for the counter-driven PWM generator.
// No ports; imported by wrap_detect and count_pwm.
package count_pwm_pkg;

  localparam int CW_DEF   = 4;
  localparam int PCW_DEF  = 8;
  localparam int MAX      = (2 ** CW_DEF) - 1;
  localparam int FULL     = 2 ** CW_DEF;

  typedef enum logic {
    EMPTY   = 1'b0,
    PENDING = 1'b1
  } slot_state_t;

  // Limit a requested high-time to one full period. Works on 32-bit values
  // so callers with any counter width can use it and size-cast the result.
  function automatic int unsigned clamp_duty(input int unsigned duty,
                                             input int unsigned full);
    return (duty > full) ? full : duty;
  endfunction

endpackage

// File: rtl/count_pwm_wrap_detect.sv
// wrap_detect: flags the cycle where the free-running counter rolls over
// from all-ones to zero. Ports: clk, rst (async active-low), count in,
// wrap out (combinational strobe, valid in the same cycle as count).
module wrap_detect
  import count_pwm_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] prev_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_count <= '0;
    end else begin
      prev_count <= count;
    end
  end

  // Only a true rollover counts; a jump to zero from any other value
  // (e.g. the counter being reset) is ignored. Reset value of prev_count
  // is zero, so the counter's own reset never looks like a wrap.
  assign wrap = (count == '0) && (prev_count == '1);

endmodule

// File: rtl/count_pwm.sv
// count_pwm: PWM generator driven by an external free-running counter;
// period = 2^CW clocks, duty updates accepted via valid/ready and applied
// only at the counter wrap. Ports: clk, rst (async active-low), count,
// duty_in/duty_valid/duty_ready, pwm_out, duty_active, period_start, period_cnt.
module count_pwm
  import count_pwm_pkg::*;
#(
  parameter int CW  = CW_DEF,
  parameter int PCW = PCW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CW-1:0]  count,
  input  logic [CW:0]    duty_in,
  input  logic           duty_valid,
  output logic           duty_ready,
  output logic           pwm_out,
  output logic [CW:0]    duty_active,
  output logic           period_start,
  output logic [PCW-1:0] period_cnt
);

  localparam int unsigned FULL_W = 2 ** CW;

  slot_state_t state;
  slot_state_t state_nxt;
  logic [CW:0] pending_val;
  logic [CW:0] duty_eff;
  logic [CW:0] duty_clamped;
  logic        pending_load;
  logic        accept;
  logic        wrap;

  wrap_detect #(.CW(CW)) u_wrap_detect (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .wrap  (wrap)
  );

  assign duty_clamped = (CW+1)'(clamp_duty(32'(duty_in), FULL_W));

  // Ready comes straight from the state register, so it never depends on
  // duty_valid in the same cycle.
  assign duty_ready = (state == EMPTY);
  assign accept     = duty_valid && duty_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the duty that governs the output registered this cycle.
  // At a wrap a held value wins over a same-cycle offer; an offer arriving
  // exactly on the wrap while the slot is empty bypasses the slot.
  always_comb begin
    state_nxt    = state;
    pending_load = 1'b0;
    duty_eff     = duty_active;
    case (state)
      EMPTY: begin
        if (accept && !wrap) begin
          state_nxt    = PENDING;
          pending_load = 1'b1;
        end else if (accept && wrap) begin
          duty_eff = duty_clamped;
        end
      end
      PENDING: begin
        if (wrap) begin
          state_nxt = EMPTY;
          duty_eff  = pending_val;
        end
      end
      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_val  <= '0;
      duty_active  <= '0;
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      period_cnt   <= '0;
    end else begin
      if (pending_load) begin
        pending_val <= duty_clamped;
      end
      if (wrap) begin
        duty_active <= duty_eff;
        period_cnt  <= period_cnt + 1'b1;
      end
      // One extra bit on count so that duty == 2^CW is always high.
      pwm_out      <= ({1'b0, count} < duty_eff);
      period_start <= wrap;
    end
  end

endmodule

// File: tb/tb_count_pwm.sv
// tb_count_pwm: directed stimulus for count_pwm with a queue-based
// scoreboard; each driven cycle pushes the expected registered outputs,
// a monitor pops and compares them one clock edge later.
module tb_count_pwm;

  logic       clk;
  logic       rst;
  logic [3:0] count;
  logic [4:0] duty_in;
  logic       duty_valid;
  logic       duty_ready;
  logic       pwm_out;
  logic [4:0] duty_active;
  logic       period_start;
  logic [7:0] period_cnt;

  count_pwm #(.CW(4), .PCW(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .duty_in      (duty_in),
    .duty_valid   (duty_valid),
    .duty_ready   (duty_ready),
    .pwm_out      (pwm_out),
    .duty_active  (duty_active),
    .period_start (period_start),
    .period_cnt   (period_cnt)
  );

  typedef struct {
    logic       pwm;
    logic [4:0] act;
    logic       rdy;
    logic       ps;
    logic [7:0] cnt;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   prev_c = 0;
  int   cnt_exp = 0;
  int   step_idx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s @step %0d: got %0d expected %0d", name, idx, got, exp);
    end
  endtask

  // Drive one counter value; act/rdy are the hand-derived duty_active and
  // duty_ready expected after the next clock edge.
  task automatic step(input int c, input bit v, input int d, input int act, input bit rdy);
    exp_t e;
    bit   wrap;
    @(negedge clk);
    count      = 4'(c);
    duty_valid = v;
    duty_in    = 5'(d);
    wrap = (c == 0) && (prev_c == 15);
    if (wrap) cnt_exp = (cnt_exp + 1) % 256;
    e.pwm = (c < act);
    e.act = 5'(act);
    e.rdy = rdy;
    e.ps  = wrap;
    e.cnt = 8'(cnt_exp);
    e.idx = step_idx;
    q.push_back(e);
    prev_c = c;
    step_idx++;
  endtask

  task automatic period(input int act);
    for (int i = 0; i < 16; i++) step(i, 1'b0, 0, act, 1'b1);
  endtask

  // Offer d at count == at in a period whose active duty is act.
  task automatic period_offer(input int act, input int at, input int d);
    for (int i = 0; i < 16; i++)
      step(i, (i == at), (i == at) ? d : 0, act, (i < at));
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pwm_out",      e.idx, int'(pwm_out),      int'(e.pwm));
        chk("duty_active",  e.idx, int'(duty_active),  int'(e.act));
        chk("duty_ready",   e.idx, int'(duty_ready),   int'(e.rdy));
        chk("period_start", e.idx, int'(period_start), int'(e.ps));
        chk("period_cnt",   e.idx, int'(period_cnt),   int'(e.cnt));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b0;
    count      = 4'd0;
    duty_in    = 5'd0;
    duty_valid = 1'b0;
    #1;
    chk("rst_pwm_out",      -1, int'(pwm_out),      0);
    chk("rst_duty_active",  -1, int'(duty_active),  0);
    chk("rst_duty_ready",   -1, int'(duty_ready),   1);
    chk("rst_period_start", -1, int'(period_start), 0);
    chk("rst_period_cnt",   -1, int'(period_cnt),   0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle: first 0 after reset is not a wrap, then one pulse per 16 clocks.
    period(0);
    period(0);
    period(0);

    // Duty 4 offered mid-period; applies from the next wrap.
    period_offer(0, 5, 4);
    period(4);
    period(4);

    // Full-high, full-low, then a clamped request.
    period_offer(4, 3, 16);
    period_offer(16, 7, 0);
    period_offer(0, 2, 25);
    period(16);

    // Bypass: offer 8 exactly on the wrap while EMPTY.
    step(0, 1'b1, 8, 8, 1'b1);
    for (int i = 1; i < 16; i++) step(i, 1'b0, 0, 8, 1'b1);

    // Pending 10 with duty_valid held high offering 3.
    for (int i = 0; i < 16; i++)
      step(i, (i >= 5), (i == 5) ? 10 : ((i > 5) ? 3 : 0), 8, (i < 5));
    step(0, 1'b1, 3, 10, 1'b1);
    step(1, 1'b1, 3, 10, 1'b0);
    for (int i = 2; i < 8; i++) step(i, 1'b0, 0, 10, 1'b0);
    // Mid-period jump 7 -> 0 is not a wrap.
    for (int i = 0; i < 16; i++) step(i, 1'b0, 0, 10, 1'b0);
    period(3);

    // Reset mid-period while a value is pending.
    for (int i = 0; i < 10; i++)
      step(i, (i == 5), (i == 5) ? 12 : 0, 3, (i < 5));
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_pwm_out",      -2, int'(pwm_out),      0);
    chk("mid_rst_duty_active",  -2, int'(duty_active),  0);
    chk("mid_rst_duty_ready",   -2, int'(duty_ready),   1);
    chk("mid_rst_period_start", -2, int'(period_start), 0);
    chk("mid_rst_period_cnt",   -2, int'(period_cnt),   0);
    @(negedge clk);
    rst     = 1'b1;
    count   = 4'd0;
    prev_c  = 0;
    cnt_exp = 0;

    // Pending 12 was discarded: duty stays 0 across the next wrap.
    period(0);
    period(0);

    @(posedge clk);
    #2;
    chk("scoreboard_drain", -3, q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
